// File: rtl/xmem_part_cfg_ctrl.sv
// Runtime partition-table controller: shadow table, validation, drain, atomic swap into the active table.
// Optional drain timeout is enabled by defining XMEM_PART_TIMEOUT_EN.
module xmem_part_cfg_ctrl #(
    parameter int unsigned XMEM_AW            = 32,
    parameter int unsigned MAX_PARTITION      = 8,
    parameter int unsigned LOG2_MAX_PARTITION = 3,
    parameter int unsigned MAX_OUTSTD         = 16
`ifdef XMEM_PART_TIMEOUT_EN
    ,
    parameter int unsigned DRAIN_TIMEOUT      = 1024
`endif
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     cfg_we,
    input  logic [LOG2_MAX_PARTITION:0]              cfg_idx,
    input  logic [XMEM_AW-1:0]                       cfg_wdata,
    input  logic                                     cfg_partNum_we,
    input  logic [LOG2_MAX_PARTITION:0]              cfg_partNum,
    input  logic                                     cfg_commit,
    output logic                                     cfg_busy,
    output logic                                     cfg_done,
    output logic [1:0]                               cfg_err,
    input  logic                                     acc_issue,
    input  logic                                     acc_done,
    output logic                                     hold_req,
    output logic [LOG2_MAX_PARTITION:0]              partNum,
    output logic [(MAX_PARTITION+1)*XMEM_AW-1:0]     rangeStart
);

    localparam int unsigned IW = LOG2_MAX_PARTITION + 1;
    localparam int unsigned NE = MAX_PARTITION + 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTD + 1);
`ifdef XMEM_PART_TIMEOUT_EN
    localparam int unsigned TW = $clog2(DRAIN_TIMEOUT + 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DRAIN,
        S_SWAP,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state, state_d;
    logic [IW-1:0]     idx, idx_d, idx_nx;
    logic [1:0]        err_code, err_code_d;
    logic [1:0]        cfg_err_d;
    logic              busy_d, hold_d, done_d;
    logic [CW-1:0]     cnt, cnt_d;
`ifdef XMEM_PART_TIMEOUT_EN
    logic [TW-1:0]     tmo, tmo_d;
`endif

    logic [IW-1:0]      sh_num;
    logic [XMEM_AW-1:0] sh_rs  [NE];
    logic [IW-1:0]      act_num;
    logic [XMEM_AW-1:0] act_rs [NE];

    logic               cfg_wr_any;

    assign idx_nx     = idx + IW'(1);
    assign cfg_wr_any = cfg_we | cfg_partNum_we;

    // Outstanding-access counter, saturating at both ends
    always_comb begin
        cnt_d = cnt;
        if (acc_issue && !acc_done) begin
            if (cnt != CW'(MAX_OUTSTD)) cnt_d = cnt + CW'(1);
        end else if (acc_done && !acc_issue) begin
            if (cnt != '0) cnt_d = cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt_d;
    end

    // FSM state and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            err_code <= '0;
            cfg_err  <= '0;
            cfg_busy <= 1'b0;
            hold_req <= 1'b0;
            cfg_done <= 1'b0;
`ifdef XMEM_PART_TIMEOUT_EN
            tmo      <= '0;
`endif
        end else begin
            state    <= state_d;
            idx      <= idx_d;
            err_code <= err_code_d;
            cfg_err  <= cfg_err_d;
            cfg_busy <= busy_d;
            hold_req <= hold_d;
            cfg_done <= done_d;
`ifdef XMEM_PART_TIMEOUT_EN
            tmo      <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d    = state;
        idx_d      = idx;
        err_code_d = err_code;
        cfg_err_d  = cfg_err;
`ifdef XMEM_PART_TIMEOUT_EN
        tmo_d      = tmo;
`endif

        case (state)
            S_IDLE: begin
                if (cfg_commit) begin
                    state_d = S_CHECK;
                    idx_d   = '0;
                end
            end
            S_CHECK: begin
                if (sh_num == '0 || sh_num > IW'(MAX_PARTITION) || !(sh_rs[idx] < sh_rs[idx_nx])) begin
                    state_d    = S_ERR;
                    err_code_d = 2'd1;
                end else if (idx_nx == sh_num) begin
                    state_d = S_DRAIN;
`ifdef XMEM_PART_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end else begin
                    idx_d = idx_nx;
                end
            end
            S_DRAIN: begin
                // A retire that empties the counter this cycle is enough to proceed
                if (cnt_d == '0) begin
                    state_d = S_SWAP;
`ifdef XMEM_PART_TIMEOUT_EN
                end else if (tmo == TW'(DRAIN_TIMEOUT - 1)) begin
                    state_d    = S_ERR;
                    err_code_d = 2'd2;
                end else begin
                    tmo_d = tmo + TW'(1);
`endif
                end
            end
            S_SWAP:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Sticky status: cleared by an accepted commit, error code lands as ERR retires
        if (state == S_IDLE && cfg_commit) begin
            cfg_err_d = 2'd0;
        end else if (state == S_ERR) begin
            cfg_err_d = err_code;
        end else if (state != S_IDLE && cfg_wr_any) begin
            cfg_err_d = 2'd3;
        end

        busy_d = (state_d == S_CHECK) || (state_d == S_DRAIN) || (state_d == S_SWAP);
        hold_d = (state_d == S_DRAIN) || (state_d == S_SWAP);
        done_d = (state_d == S_DONE);
    end

    // Shadow table: writable only while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_num <= IW'(1);
            for (int p = 0; p < NE; p++) sh_rs[p] <= (p == 0) ? '0 : '1;
        end else if (state == S_IDLE) begin
            if (cfg_we && (cfg_idx <= IW'(MAX_PARTITION))) sh_rs[cfg_idx] <= cfg_wdata;
            if (cfg_partNum_we) sh_num <= cfg_partNum;
        end
    end

    // Active table: changes only on the swap edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_num <= IW'(1);
            for (int p = 0; p < NE; p++) act_rs[p] <= (p == 0) ? '0 : '1;
        end else if (state == S_SWAP) begin
            act_num <= sh_num;
            for (int p = 0; p < NE; p++) act_rs[p] <= sh_rs[p];
        end
    end

    assign partNum = act_num;

    for (genvar p = 0; p < NE; p++) begin : g_out
        assign rangeStart[p*XMEM_AW +: XMEM_AW] = act_rs[p];
    end

endmodule

// File: tb/tb_xmem_part_cfg_ctrl.sv
// Bench for xmem_part_cfg_ctrl: directed scenarios plus random traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_xmem_part_cfg_ctrl;

    localparam int unsigned AW   = 32;
    localparam int unsigned MAXP = 8;
    localparam int unsigned LG   = 3;
    localparam int unsigned IW   = LG + 1;
    localparam int unsigned NE   = MAXP + 1;
    localparam int          MOUT = 16;
`ifdef XMEM_PART_TIMEOUT_EN
    localparam int          TMO  = 1024;
`endif

    typedef logic [NE*AW-1:0] wide_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [AW-1:0] cfg_wdata = '0;
    logic          cfg_partNum_we = 1'b0;
    logic [IW-1:0] cfg_partNum = '0;
    logic          cfg_commit = 1'b0;
    logic          acc_issue = 1'b0;
    logic          acc_done = 1'b0;
    logic          cfg_busy, cfg_done, hold_req;
    logic [1:0]    cfg_err;
    logic [IW-1:0] partNum;
    wide_t         rangeStart;

    always #5 clk = ~clk;

    xmem_part_cfg_ctrl #(
        .XMEM_AW(AW), .MAX_PARTITION(MAXP), .LOG2_MAX_PARTITION(LG), .MAX_OUTSTD(MOUT)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_wdata(cfg_wdata),
        .cfg_partNum_we(cfg_partNum_we), .cfg_partNum(cfg_partNum), .cfg_commit(cfg_commit),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
        .acc_issue(acc_issue), .acc_done(acc_done), .hold_req(hold_req),
        .partNum(partNum), .rangeStart(rangeStart)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input wide_t act, input wide_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Transaction-level model: a commit is judged as a whole, then walks through its phases
    typedef enum int {P_IDLE, P_CHECK, P_DRAIN, P_SWAP, P_DONE, P_ERR} phase_t;
    phase_t        ph;
    int            left, m_cnt;
    bit            fresh, m_ok;
    logic [1:0]    m_err, m_code;
    logic [IW-1:0] m_num, a_num;
    logic [AW-1:0] m_rs [NE];
    logic [AW-1:0] a_rs [NE];
`ifdef XMEM_PART_TIMEOUT_EN
    int            dcyc;
`endif

    function automatic int verdict(output bit ok);
        int n = int'(m_num);
        ok = 1'b0;
        if (n == 0 || n > int'(MAXP)) return 1;
        for (int k = 0; k < n; k++) if (m_rs[k] >= m_rs[k+1]) return k + 1;
        ok = 1'b1;
        return n;
    endfunction

    task automatic model_reset();
        ph = P_IDLE; left = 0; m_cnt = 0; fresh = 1'b0; m_ok = 1'b0;
        m_err = '0; m_code = '0; m_num = IW'(1); a_num = IW'(1);
        for (int p = 0; p < NE; p++) begin
            m_rs[p] = (p == 0) ? '0 : '1;
            a_rs[p] = (p == 0) ? '0 : '1;
        end
    endtask

    task automatic model_step();
        int cn = m_cnt;
        bit idle = (ph == P_IDLE);
        if (acc_issue && !acc_done) cn = (cn < MOUT) ? cn + 1 : cn;
        else if (acc_done && !acc_issue) cn = (cn > 0) ? cn - 1 : cn;
        if (idle && cfg_commit) m_err = 2'd0;
        else if (ph == P_ERR) m_err = m_code;
        else if (!idle && (cfg_we || cfg_partNum_we)) m_err = 2'd3;
        case (ph)
            P_IDLE: if (cfg_commit) begin ph = P_CHECK; fresh = 1'b1; end
            P_CHECK: begin
                if (fresh) begin left = verdict(m_ok); fresh = 1'b0; end
                left--;
                if (left == 0) begin
                    if (m_ok) begin
                        ph = P_DRAIN;
`ifdef XMEM_PART_TIMEOUT_EN
                        dcyc = 0;
`endif
                    end else begin
                        ph = P_ERR; m_code = 2'd1;
                    end
                end
            end
            P_DRAIN: begin
                if (cn == 0) ph = P_SWAP;
`ifdef XMEM_PART_TIMEOUT_EN
                else begin
                    dcyc++;
                    if (dcyc == TMO) begin ph = P_ERR; m_code = 2'd2; end
                end
`endif
            end
            P_SWAP: begin a_num = m_num; a_rs = m_rs; ph = P_DONE; end
            default: ph = P_IDLE;
        endcase
        if (idle) begin
            if (cfg_we && int'(cfg_idx) <= int'(MAXP)) m_rs[cfg_idx] = cfg_wdata;
            if (cfg_partNum_we) m_num = cfg_partNum;
        end
        m_cnt = cn;
    endtask

    task automatic compare_all();
        wide_t ef;
        for (int p = 0; p < NE; p++) ef[p*AW +: AW] = a_rs[p];
        chk("busy", wide_t'(cfg_busy), wide_t'(ph == P_CHECK || ph == P_DRAIN || ph == P_SWAP));
        chk("hold", wide_t'(hold_req), wide_t'(ph == P_DRAIN || ph == P_SWAP));
        chk("done", wide_t'(cfg_done), wide_t'(ph == P_DONE));
        chk("err", wide_t'(cfg_err), wide_t'(m_err));
        chk("pnum", wide_t'(partNum), wide_t'(a_num));
        chk("range", rangeStart, ef);
    endtask

    task automatic wr(input int idx, input logic [AW-1:0] d);
        cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic wr_num(input int n);
        cfg_partNum_we = 1'b1; cfg_partNum = IW'(n);
        @(negedge clk);
        cfg_partNum_we = 1'b0;
    endtask

    task automatic pulse_commit();
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
    endtask

    task automatic commit_watch(input int budget, output int done_at, output int err_at, output int holds);
        pulse_commit();
        done_at = -1; err_at = -1; holds = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (hold_req) holds++;
            if (cfg_done && done_at < 0) done_at = c;
            if (cfg_err != 2'd0 && !cfg_busy && err_at < 0) err_at = c;
            if (!cfg_busy && !hold_req && (done_at >= 0 || err_at >= 0)) break;
        end
    endtask

    task automatic wait_hold(input string nm);
        for (int c = 0; c < 40 && !hold_req; c++) @(negedge clk);
        chk(nm, wide_t'(hold_req), wide_t'(1));
    endtask

    wide_t rst_flat, t2_flat;
    int    done_at, err_at, holds, r;

    initial begin
        for (int p = 0; p < NE; p++) rst_flat[p*AW +: AW] = (p == 0) ? '0 : '1;
        t2_flat = rst_flat;
        t2_flat[4*AW-1:0] = {32'h1000, 32'h400, 32'h100, 32'h0};
        model_reset();
        fork
            forever begin
                @(posedge clk or posedge rst);
                if (rst) model_reset();
                else     model_step();
            end
            forever begin
                @(posedge clk);
                #1;
                compare_all();
            end
        join_none

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_pnum", wide_t'(partNum), wide_t'(1));
        chk("rst_rs0", wide_t'(rangeStart[AW-1:0]), wide_t'(0));
        chk("rst_rs1", wide_t'(rangeStart[2*AW-1:AW]), wide_t'(32'hFFFF_FFFF));
        chk("rst_hold", wide_t'(hold_req), wide_t'(0));
        chk("rst_err", wide_t'(cfg_err), wide_t'(0));
        @(negedge clk);

        // Valid three-partition table with nothing in flight
        wr_num(3); wr(1, 32'h100); wr(2, 32'h400); wr(3, 32'h1000);
        commit_watch(20, done_at, err_at, holds);
        chk("t2_done_at", wide_t'(done_at), wide_t'(5));
        chk("t2_holds", wide_t'(holds), wide_t'(2));
        chk("t2_pnum", wide_t'(partNum), wide_t'(3));
        chk("t2_table", rangeStart, t2_flat);

        // Non-increasing pair rejected, active table kept
        wr_num(2); wr(1, 32'h400); wr(2, 32'h100);
        commit_watch(20, done_at, err_at, holds);
        chk("t3_err_at", wide_t'(err_at), wide_t'(3));
        chk("t3_err", wide_t'(cfg_err), wide_t'(1));
        chk("t3_holds", wide_t'(holds), wide_t'(0));
        chk("t3_table", rangeStart, t2_flat);

        // Three outstanding; simultaneous issue+retire leaves count unchanged
        wr_num(3); wr(1, 32'h100); wr(2, 32'h400);
        acc_issue = 1'b1; repeat (3) @(negedge clk);
        acc_done = 1'b1; @(negedge clk);
        acc_issue = 1'b0; acc_done = 1'b0;
        pulse_commit();
        wait_hold("t4_hold_up");
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            acc_done = 1'b1; @(negedge clk); acc_done = 1'b0; @(negedge clk);
            chk("t4_still_hold", wide_t'({hold_req, cfg_done}), wide_t'(2'b10));
        end
        acc_done = 1'b1; @(negedge clk); acc_done = 1'b0;
        chk("t4_swap", wide_t'({hold_req, cfg_done}), wide_t'(2'b10));
        @(negedge clk);
        chk("t4_done", wide_t'({hold_req, cfg_done}), wide_t'(2'b01));

        // Counter saturates at MAX_OUTSTD: 20 issues need only 16 retires
        acc_issue = 1'b1; repeat (20) @(negedge clk); acc_issue = 1'b0;
        pulse_commit();
        wait_hold("sat_hold_up");
        acc_done = 1'b1; repeat (15) @(negedge clk); acc_done = 1'b0;
        @(negedge clk);
        chk("sat_draining", wide_t'({hold_req, cfg_done}), wide_t'(2'b10));
        acc_done = 1'b1; @(negedge clk); acc_done = 1'b0;
        @(negedge clk);
        chk("sat_done", wide_t'(cfg_done), wide_t'(1));

        // Write during drain is dropped and flagged
        acc_issue = 1'b1; @(negedge clk); acc_issue = 1'b0;
        pulse_commit();
        wait_hold("t5_hold_up");
        wr(1, 32'hDEAD);
        chk("t5_err3", wide_t'(cfg_err), wide_t'(3));
`ifdef XMEM_PART_TIMEOUT_EN
        for (int c = 0; c < TMO + 20 && cfg_err != 2'd2; c++) @(negedge clk);
        chk("t5_err2", wide_t'(cfg_err), wide_t'(2));
        chk("t5_tmo_table", rangeStart, t2_flat);
        acc_done = 1'b1; @(negedge clk); acc_done = 1'b0;
        @(negedge clk);
`else
        repeat (5) @(negedge clk);
        acc_done = 1'b1; @(negedge clk); acc_done = 1'b0;
        @(negedge clk);
        chk("t5_done", wide_t'(cfg_done), wide_t'(1));
        chk("t5_dropped", wide_t'(rangeStart[2*AW-1:AW]), wide_t'(32'h100));
`endif
        @(negedge clk);

        // Asynchronous reset in the middle of a drain
        acc_issue = 1'b1; @(negedge clk); acc_issue = 1'b0;
        pulse_commit();
        wait_hold("t6_hold_up");
        #2 rst = 1'b1;
        #1;
        chk("t6_hold", wide_t'(hold_req), wide_t'(0));
        chk("t6_pnum", wide_t'(partNum), wide_t'(1));
        chk("t6_table", rangeStart, rst_flat);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wr_num(0);
        commit_watch(20, done_at, err_at, holds);
        chk("t6_zero_err_at", wide_t'(err_at), wide_t'(2));
        chk("t6_zero_err", wide_t'(cfg_err), wide_t'(1));
        chk("t6_zero_pnum", wide_t'(partNum), wide_t'(1));

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            acc_issue      = (ph != P_DRAIN && ph != P_SWAP) && ($urandom_range(0, 3) == 0);
            acc_done       = (m_cnt > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 30) == 0);
            cfg_we         = (r < 8);
            cfg_idx        = IW'($urandom_range(0, NE));
            cfg_wdata      = (r < 6) ? AW'(int'(cfg_idx) * 256 + int'($urandom_range(0, 255))) : AW'($urandom);
            cfg_partNum_we = (r >= 8 && r < 11);
            cfg_partNum    = (r == 8) ? IW'($urandom_range(0, 15)) : IW'($urandom_range(1, MAXP));
            cfg_commit     = (r >= 90);
            @(negedge clk);
        end
        cfg_we = 1'b0; cfg_partNum_we = 1'b0; cfg_commit = 1'b0; acc_issue = 1'b0;
        for (int c = 0; c < 2000 && !(ph == P_IDLE && m_cnt == 0); c++) begin
            acc_done = (m_cnt > 0);
            @(negedge clk);
        end
        acc_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("end_idle", wide_t'(cfg_busy), wide_t'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
